// File: rtl/mac_sched_if.sv
// ---------------------------------------------------------------------------
// mac_sched_if
//   Bus bundle between the MAC sequencer and its environment. It carries the
//   feature-memory read port, the MAC issue/return handshake and the
//   result-memory write port.
//   master : the sequencer (drives read strobe/address, MAC operands, writes)
//   slave  : the environment (feature SRAM, mac, result SRAM)
// Signals
//   feat_rd_en / feat_rd_addr  read strobe and node address to feature SRAM
//   feat_rd_data               {x3,x2,x1,x0}, valid one cycle after feat_rd_en
//   mac_x / mac_in_ready       operands to the mac and their one-cycle strobe
//   mac_ready / mac_out        mac result valid and {out3,out2,out1,out0}
//   res_wr_en / res_wr_addr /
//   res_wr_data                result SRAM write port
// ---------------------------------------------------------------------------
interface mac_sched_if #(
    parameter int MAC_IN_SIZE  = 5,
    parameter int MAC_OUT_SIZE = 13,
    parameter int ADDR_W       = 4
);
    logic                      feat_rd_en;
    logic [ADDR_W-1:0]         feat_rd_addr;
    logic [4*MAC_IN_SIZE-1:0]  feat_rd_data;
    logic [4*MAC_IN_SIZE-1:0]  mac_x;
    logic                      mac_in_ready;
    logic                      mac_ready;
    logic [4*MAC_OUT_SIZE-1:0] mac_out;
    logic                      res_wr_en;
    logic [ADDR_W-1:0]         res_wr_addr;
    logic [4*MAC_OUT_SIZE-1:0] res_wr_data;

    modport master (
        output feat_rd_en, feat_rd_addr, mac_x, mac_in_ready,
               res_wr_en, res_wr_addr, res_wr_data,
        input  feat_rd_data, mac_ready, mac_out
    );

    modport slave (
        input  feat_rd_en, feat_rd_addr, mac_x, mac_in_ready,
               res_wr_en, res_wr_addr, res_wr_data,
        output feat_rd_data, mac_ready, mac_out
    );
endinterface

// File: rtl/mac_sched.sv
// ---------------------------------------------------------------------------
// mac_sched
//   Sequencer for the 4x4 signed MAC stage of the GNN layer. A pass walks node
//   indices 0..N-1: read the node's packed feature vector, capture it into the
//   MAC operand register, strobe the mac for one cycle, then wait for the mac
//   result and write it (optionally ReLU-clamped) to result memory.
// Ports
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   start            begin a pass (only looked at while idle)
//   abort            drop the current pass, back to idle, no done pulse
//   cfg_num_nodes    node count N, latched when start is accepted
//   busy             high whenever the sequencer is not idle
//   done             one-cycle pulse when a pass completes normally
//   bus (master)     feature read port, mac handshake, result write port
// ---------------------------------------------------------------------------
module mac_sched #(
    parameter int MAC_IN_SIZE  = 5,
    parameter int MAC_OUT_SIZE = 13,
    parameter int ADDR_W       = 4,
    parameter bit RELU_EN      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_num_nodes,
    output logic              busy,
    output logic              done,
    mac_sched_if.master       bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_MAC,
        S_WB,
        S_DONE
    } state_t;

    state_t                    state_q;
    logic [ADDR_W-1:0]         idx_q;
    logic [ADDR_W-1:0]         count_q;
    logic [4*MAC_IN_SIZE-1:0]  mac_x_q;

    logic [ADDR_W-1:0]         last_idx;
    logic                      wr_fire;
    logic [4*MAC_OUT_SIZE-1:0] res_data_d;

    // count_q is never 0 outside IDLE/DONE, so last_idx cannot underflow
    // where it is used.
    assign last_idx = count_q - 1'b1;
    assign wr_fire  = (state_q == S_WB) && bus.mac_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    // NOTE: only control and the operand register are reset; the datapath has
    // no storage array, so nothing large needs a reset fan-out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            count_q <= '0;
            mac_x_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // abort wins over start while idle
                    if (start && !abort) begin
                        count_q <= cfg_num_nodes;
                        idx_q   <= '0;
                        state_q <= (cfg_num_nodes != '0) ? S_READ : S_DONE;
                    end
                end
                S_READ: begin
                    state_q <= abort ? S_IDLE : S_CAPT;
                end
                S_CAPT: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        mac_x_q <= bus.feat_rd_data;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    state_q <= abort ? S_IDLE : S_WB;
                end
                S_WB: begin
                    // A WB cycle that sees mac_ready writes even under abort;
                    // abort only decides where we go next.
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (bus.mac_ready) begin
                        if (idx_q == last_idx) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Per-lane ReLU on the mac result.
    // NOTE: the output is given its default before the loop, so every path
    // through the block assigns it and no latch is inferred.
    always_comb begin
        res_data_d = bus.mac_out;
        if (RELU_EN) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mac_out[i*MAC_OUT_SIZE + MAC_OUT_SIZE - 1]) begin
                    res_data_d[i*MAC_OUT_SIZE +: MAC_OUT_SIZE] = '0;
                end
            end
        end
    end

    // Strobes decode straight from the state register; addresses and write
    // data are forced to zero whenever their strobe is low.
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign bus.feat_rd_en   = (state_q == S_READ);
    assign bus.feat_rd_addr = (state_q == S_READ) ? idx_q : '0;
    assign bus.mac_x        = mac_x_q;
    assign bus.mac_in_ready = (state_q == S_MAC);
    assign bus.res_wr_en    = wr_fire;
    assign bus.res_wr_addr  = wr_fire ? idx_q : '0;
    assign bus.res_wr_data  = wr_fire ? res_data_d : '0;

endmodule
